// File: rtl/comm_defs_pkg.sv
// comm_defs_pkg: definitions shared by the UART autobaud controller.
//   - ab_state_e : autobaud FSM states
//   - DIV[16]    : baudmux divider per baud select (1 bit = 4*DIV clocks)
//   - TH[16]     : measurement thresholds, TH[i] = 18*(DIV[i]+DIV[i+1])
//   - ERR_*      : err_code values
//   - th_encode  : priority encoder, smallest i with meas >= TH[i]
package comm_defs_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      AB_IDLE,
      AB_ARM,
      AB_WAIT_FALL,
      AB_MEASURE,
      AB_DECIDE
   } ab_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SHORT   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [11:0] DIV [16] = '{
      12'd1302, 12'd217, 12'd108, 12'd54, 12'd27, 12'd22, 12'd20, 12'd19,
      12'd16,   12'd15,  12'd10,  12'd8,  12'd6,  12'd5,  12'd4,  12'd2
   };

   // Midpoints between adjacent dividers scaled to a 9-bit-time window
   localparam logic [CNT_W-1:0] TH [16] = '{
      16'd27342, 16'd5850, 16'd2916, 16'd1458, 16'd882, 16'd756, 16'd702, 16'd630,
      16'd558,   16'd450,  16'd324,  16'd252,  16'd198, 16'd162, 16'd108, 16'd0
   };

   // Scan from the high index down so the smallest matching index wins
   function automatic logic [3:0] th_encode(input logic [CNT_W-1:0] m);
      logic [3:0] sel;
      sel = 4'd15;
      for (int i = 14; i >= 0; i--) begin
         if (m >= TH[i]) sel = i[3:0];
      end
      return sel;
   endfunction

endpackage

// File: rtl/baudmux.sv
// baudmux: decodes the 4-bit baud select into the 12-bit bit-engine divider.
//   baud_sel_i : baud select
//   baud_div_o : divider (combinational)
module baudmux
   import comm_defs_pkg::*;
(
   input  logic [3:0]  baud_sel_i,
   output logic [11:0] baud_div_o
);

   assign baud_div_o = DIV[baud_sel_i];

endmodule

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a received 0x55 sync character and picks a baud select.
//   clk, rst_n : clock, synchronous active-low reset
//   rx_i       : asynchronous RX line (idle high)
//   start      : begin a detection (ignored while busy)
//   abort      : cancel a detection (wins over start)
//   baud_sel   : registered baud select, updated only on success
//   baud_div   : divider decoded from baud_sel
//   busy       : detection in progress
//   done/err   : one-cycle success / failure pulses
//   err_code   : 01 too short, 10 timeout; held until next start
//   meas_cyc   : last measured cycle count; held until next start
module uart_autobaud
   import comm_defs_pkg::*;
#(
   parameter logic [3:0]       RST_SEL = 4'd1,
   parameter logic [CNT_W-1:0] MIN_CYC = 16'd54
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_i,
   input  logic             start,
   input  logic             abort,
   output logic [3:0]       baud_sel,
   output logic [11:0]      baud_div,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] meas_cyc
);

   // Synchronizer plus edge-detect flop; all reset to the idle level
   logic s1_q, s2_q, s3_q;
   logic fall, rise;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign fall = s3_q & ~s2_q;
   assign rise = ~s3_q & s2_q;

   ab_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       rise_cnt_q;
   logic [3:0]       sel_q;
   logic             done_q, err_q;
   logic [1:0]       code_q;
   logic [CNT_W-1:0] meas_q;

   // Counter value including the detection cycle itself, so the latched
   // count equals the edge-to-edge distance on the synchronized line.
   logic [CNT_W-1:0] meas_d;
   logic [3:0]       sel_d;

   assign meas_d = cnt_q + 1'b1;
   assign sel_d  = th_encode(meas_d);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= AB_IDLE;
         cnt_q      <= '0;
         rise_cnt_q <= '0;
         sel_q      <= RST_SEL;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
         meas_q     <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            AB_IDLE: begin
               if (start && !abort) begin
                  state_q <= AB_ARM;
                  code_q  <= ERR_NONE;
                  meas_q  <= '0;
               end
            end
            AB_ARM: begin
               if (abort)     state_q <= AB_IDLE;
               else if (s2_q) state_q <= AB_WAIT_FALL;
            end
            AB_WAIT_FALL: begin
               if (abort) begin
                  state_q <= AB_IDLE;
               end else if (fall) begin
                  state_q    <= AB_MEASURE;
                  cnt_q      <= '0;
                  rise_cnt_q <= '0;
               end
            end
            AB_MEASURE: begin
               if (abort) begin
                  state_q <= AB_IDLE;
               end else if (cnt_q == '1) begin
                  // Saturated: line never completed the character
                  state_q <= AB_DECIDE;
                  err_q   <= 1'b1;
                  code_q  <= ERR_TIMEOUT;
                  meas_q  <= '1;
               end else begin
                  cnt_q <= meas_d;
                  if (rise) begin
                     if (rise_cnt_q == 3'd4) begin
                        state_q <= AB_DECIDE;
                        meas_q  <= meas_d;
                        if (meas_d < MIN_CYC) begin
                           err_q  <= 1'b1;
                           code_q <= ERR_SHORT;
                        end else begin
                           done_q <= 1'b1;
                           sel_q  <= sel_d;
                        end
                     end else begin
                        rise_cnt_q <= rise_cnt_q + 3'd1;
                     end
                  end
               end
            end
            AB_DECIDE: state_q <= AB_IDLE;
            default:   state_q <= AB_IDLE;
         endcase
      end
   end

   baudmux u_baudmux (
      .baud_sel_i (sel_q),
      .baud_div_o (baud_div)
   );

   assign baud_sel = sel_q;
   assign busy     = (state_q != AB_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = code_q;
   assign meas_cyc = meas_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed + randomized bench for uart_autobaud.
// Expected baud select comes from a nearest-divider model: the chosen
// divider is the one whose ideal 36*div window is closest to the
// measurement, ties resolved toward the slower rate (lower index).
module tb_uart_autobaud;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_i = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  baud_sel;
   logic [11:0] baud_div;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [15:0] meas_cyc;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int n_errp = 0;
   int cur_sel = 1;
   int div_tab [16] = '{1302, 217, 108, 54, 27, 22, 20, 19, 16, 15, 10, 8, 6, 5, 4, 2};

   uart_autobaud dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_i     (rx_i),
      .start    (start),
      .abort    (abort),
      .baud_sel (baud_sel),
      .baud_div (baud_div),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .meas_cyc (meas_cyc)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) n_done++;
      if (err)  n_errp++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_sel(input int m);
      int best, bd, d;
      best = 0;
      bd = m - 36 * div_tab[0];
      if (bd < 0) bd = -bd;
      for (int i = 1; i < 16; i++) begin
         d = m - 36 * div_tab[i];
         if (d < 0) d = -d;
         if (d < bd) begin
            bd = d;
            best = i;
         end
      end
      return best;
   endfunction

   // Drives low/high segments (9 of them, starting low); the 9th segment
   // ends with the 5th rising edge. poke re-pulses start mid-measurement.
   task automatic run_meas(input string tag, input int seg [9], input bit poke);
      int m = 0;
      bit got = 0;
      int esel;
      bit exp_ok;
      foreach (seg[i]) m += seg[i];
      exp_ok = (m >= 54);
      esel = exp_ok ? model_sel(m) : cur_sel;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         rx_i = (i % 2 == 1);
         if (poke && i == 4) begin
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (seg[i] - 1) @(negedge clk);
         end else begin
            repeat (seg[i]) @(negedge clk);
         end
      end
      rx_i = 1'b1;
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge clk);
         if (done || err) got = 1;
      end
      chk({tag, ".result_seen"}, got, 1);
      if (got) begin
         chk({tag, ".done"}, done, exp_ok);
         chk({tag, ".err"}, err, !exp_ok);
         chk({tag, ".meas_cyc"}, meas_cyc, m);
         chk({tag, ".err_code"}, err_code, exp_ok ? 2'b00 : 2'b01);
         chk({tag, ".baud_sel"}, baud_sel, esel);
         chk({tag, ".baud_div"}, baud_div, div_tab[esel]);
         @(negedge clk);
         chk({tag, ".busy_after"}, busy, 0);
      end
      cur_sel = esel;
      repeat (3) @(negedge clk);
   endtask

   task automatic ideal(input string tag, input int dv, input bit poke);
      int b;
      int s [9];
      b = 4 * dv;
      s = '{b, b, b, b, b, b, b, b, b};
      run_meas(tag, s, poke);
   endtask

   task automatic short_m(input string tag, input int m);
      int s [9];
      s = '{2, 2, 2, 2, 2, 2, 2, 2, m - 16};
      run_meas(tag, s, 1'b0);
   endtask

   initial begin
      int s [9];
      bit got;
      int nd, ne;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.baud_sel", baud_sel, 1);
      chk("rst.baud_div", baud_div, 217);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.err", err, 0);
      chk("rst.err_code", err_code, 0);
      chk("rst.meas_cyc", meas_cyc, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Ideal characters (div22 also re-pulses start while busy)
      ideal("div22", 22, 1'b1);
      ideal("div2", 2, 1'b0);
      short_m("glitch40", 40);
      short_m("bnd5850", 5850);
      short_m("bnd5849", 5849);
      short_m("bnd108", 108);
      short_m("bnd107", 107);
      ideal("div217", 217, 1'b0);

      // Randomized segment lengths
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 9; i++) s[i] = $urandom_range(2, 120);
         run_meas("rand", s, 1'b0);
      end

      // Timeout: line falls and stays low
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b0;
      got = 0;
      for (int k = 0; k < 66000 && !got; k++) begin
         @(negedge clk);
         if (done || err) got = 1;
      end
      chk("tout.seen", got, 1);
      chk("tout.err", err, 1);
      chk("tout.done", done, 0);
      chk("tout.err_code", err_code, 2);
      chk("tout.meas_cyc", meas_cyc, 16'hFFFF);
      chk("tout.baud_sel", baud_sel, cur_sel);
      @(negedge clk);
      chk("tout.busy_after", busy, 0);
      chk("tout.code_held", err_code, 2);
      rx_i = 1'b1;
      repeat (4) @(negedge clk);

      // Accepted start clears status; busy rises next cycle; abort in ARM
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("clr.busy", busy, 1);
      chk("clr.err_code", err_code, 0);
      chk("clr.meas_cyc", meas_cyc, 0);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_arm.busy", busy, 0);

      // Abort mid-measure: no done/err
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort_meas.busy_before", busy, 1);
      nd = n_done;
      ne = n_errp;
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_meas.busy", busy, 0);
      rx_i = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_meas.no_done", n_done, nd);
      chk("abort_meas.no_err", n_errp, ne);
      chk("abort_meas.baud_sel", baud_sel, cur_sel);

      // start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort.busy", busy, 0);
      @(negedge clk);
      chk("start_abort.busy2", busy, 0);

      // Move off the reset select, then reset mid-measure
      ideal("div2b", 2, 1'b0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid.baud_sel", baud_sel, 1);
      chk("rst_mid.baud_div", baud_div, 217);
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.meas_cyc", meas_cyc, 0);
      chk("rst_mid.err_code", err_code, 0);
      rst_n = 1'b1;
      rx_i = 1'b1;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
